apb_req_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one amba APB master between NREQ requesters.

---
 rtl/apb_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NREQ requesters; snoops the bus for completion.
// Optional grant locking is compiled in with `define ARB_LOCK_EN.
module apb_req_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              transfer,
  output logic              mpwrite,
  output logic [AW-1:0]     apb_write_paddr,
  output logic [AW-1:0]     apb_read_paddr,
  output logic [DW-1:0]     apb_write_data,
  input  logic              psel,
  input  logic              penable,
  input  logic              pready,
  input  logic [DW-1:0]     prdata
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            transfer_q, transfer_d;
  logic            mpwrite_q, mpwrite_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic            lock_hold;
  logic            setup_seen;
  logic            access_done;

  // Scan starts just past the last owner so the most recent winner has lowest priority.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int unsigned cand;
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
`ifdef ARB_LOCK_EN
    lock_hold = req_lock[owner_q] & req[owner_q];
`else
    lock_hold = 1'b0 & (|req_lock);
`endif
  end

  assign setup_seen  = psel & ~penable;
  assign access_done = psel & penable & pready;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    transfer_d = transfer_q;
    mpwrite_d  = mpwrite_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          transfer_d     = 1'b1;
          mpwrite_d      = req_write[win_idx];
          addr_d         = req_addr[int'(win_idx)*AW +: AW];
          wdata_d        = req_wdata[int'(win_idx)*DW +: DW];
          state_d        = REQ;
        end
      end

      REQ: begin
        if (setup_seen) begin
          transfer_d = 1'b0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        if (access_done) begin
          done_d[owner_q] = 1'b1;
          if (!mpwrite_q) rdata_d = prdata;
          if (lock_hold) begin
            // Locked owner keeps the grant and reissues directly; rotation pointer untouched.
            transfer_d = 1'b1;
            mpwrite_d  = req_write[owner_q];
            addr_d     = req_addr[int'(owner_q)*AW +: AW];
            wdata_d    = req_wdata[int'(owner_q)*DW +: DW];
            state_d    = REQ;
          end else begin
            gnt_d    = '0;
            rr_ptr_d = owner_q;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      transfer_q <= 1'b0;
      mpwrite_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rr_ptr_q   <= PW'(NREQ - 1);
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      transfer_q <= transfer_d;
      mpwrite_q  <= mpwrite_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign rdata           = rdata_q;
  assign transfer        = transfer_q;
  assign mpwrite         = mpwrite_q;
  assign apb_write_paddr = addr_q;
  assign apb_read_paddr  = addr_q;
  assign apb_write_data  = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter with a small APB master model that registers transfer.
// Expected completions are queued by the stimulus and popped by the monitor on each done pulse.
module tb_apb_req_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic               pclk = 1'b0;
  logic               presetn;
  logic [NREQ-1:0]    req, req_write, req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      rdata, apb_write_data, prdata;
  logic               transfer, mpwrite, psel, penable, pready;
  logic [AW-1:0]      apb_write_paddr, apb_read_paddr;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .pclk(pclk), .presetn(presetn),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lock(req_lock), .gnt(gnt), .done(done), .rdata(rdata),
    .transfer(transfer), .mpwrite(mpwrite),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data),
    .psel(psel), .penable(penable), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // APB master model: one cycle to register transfer, then SETUP, then ACCESS with wait states.
  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} m_state_e;
  m_state_e      m_state;
  logic          tr_q;
  int            m_cnt;
  int            wait_states;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_write;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_state <= M_IDLE;
      tr_q    <= 1'b0;
      m_cnt   <= 0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_write <= 1'b0;
    end else begin
      tr_q <= transfer;
      case (m_state)
        M_IDLE: if (tr_q) begin
          m_state <= M_SETUP;
          m_write <= mpwrite;
          m_addr  <= mpwrite ? apb_write_paddr : apb_read_paddr;
          m_wdata <= apb_write_data;
        end
        M_SETUP: begin
          m_state <= M_ACCESS;
          m_cnt   <= wait_states;
        end
        default: if (m_cnt == 0) m_state <= M_IDLE;
                 else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  assign psel    = (m_state != M_IDLE);
  assign penable = (m_state == M_ACCESS);
  assign pready  = (m_state == M_ACCESS) && (m_cnt == 0);

  typedef struct {
    int            idx;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  logic [DW-1:0] last_rd;
  int            checks = 0;
  int            errors = 0;
  int            ndone  = 0;
  int            gnt_zero;
  bit            watch = 1'b0;
  bit            done_prev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] rd);
    exp_t x;
    x.idx = idx; x.wr = wr; x.addr = a; x.wdata = d;
    if (!wr) last_rd = rd;
    x.rdata = last_rd;
    exp_q.push_back(x);
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]        = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req[i]              = 1'b1;
  endtask

  task automatic wait_done(input int n, input string nm);
    int target;
    target = ndone + n;
    for (int i = 0; i < 200 && ndone < target; i++) begin
      @(negedge pclk); #1;
    end
    check({nm, "_timeout"}, ndone >= target, 1);
  endtask

  // Monitor: one-hot grant, single-cycle done, and scoreboard comparison on every completion.
  always @(negedge pclk) begin
    if (!presetn) begin
      done_prev = 1'b0;
    end else begin
      check("gnt_onehot0", ($countones(gnt) <= 1) ? 1 : 0, 1);
      if (watch && gnt == '0 && done == '0) gnt_zero++;
      if (done != '0) begin
        check("done_one_cycle", done_prev, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got %0h expected none", done);
        end else begin
          e = exp_q.pop_front();
          check("done_idx", done, 1 << e.idx);
          check("bus_write", m_write, e.wr);
          check("bus_addr", m_addr, e.addr);
          if (e.wr) check("bus_wdata", m_wdata, e.wdata);
          check("rdata", rdata, e.rdata);
        end
        ndone++;
      end
      done_prev = (done != '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit gnt_dropped;
    presetn = 1'b0; req = '0; req_write = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; prdata = '0; wait_states = 0; last_rd = '0;
    repeat (3) @(negedge pclk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_transfer", transfer, 0);
    check("rst_mpwrite", mpwrite, 0);
    check("rst_waddr", apb_write_paddr, 0);
    check("rst_raddr", apb_read_paddr, 0);
    check("rst_wdata", apb_write_data, 0);
    @(negedge pclk);
    presetn = 1'b1;

    // 1: single write from requester 0
    @(negedge pclk);
    set_req(0, 1'b1, 8'h10, 8'hA5);
    push_exp(0, 1'b1, 8'h10, 8'hA5, 8'h00);
    @(negedge pclk); #1;
    check("t1_gnt", gnt, 2'b01);
    check("t1_transfer", transfer, 1);
    check("t1_mpwrite", mpwrite, 1);
    check("t1_paddr", apb_write_paddr, 8'h10);
    check("t1_pwdata", apb_write_data, 8'hA5);
    wait_done(1, "t1");
    req = '0;

    // 2: read from requester 1
    @(negedge pclk);
    prdata = 8'h5C;
    set_req(1, 1'b0, 8'h22, 8'h00);
    push_exp(1, 1'b0, 8'h22, 8'h00, 8'h5C);
    @(negedge pclk); #1;
    check("t2_gnt", gnt, 2'b10);
    check("t2_mpwrite", mpwrite, 0);
    check("t2_raddr", apb_read_paddr, 8'h22);
    wait_done(1, "t2");
    req = '0;
    check("t2_rdata", rdata, 8'h5C);

    // 3: both requesting continuously -> 0,1,0,1
    @(negedge pclk);
    prdata = 8'h3C;
    set_req(0, 1'b1, 8'h31, 8'h11);
    set_req(1, 1'b0, 8'h33, 8'h00);
    push_exp(0, 1'b1, 8'h31, 8'h11, 8'h00);
    push_exp(1, 1'b0, 8'h33, 8'h00, 8'h3C);
    push_exp(0, 1'b1, 8'h31, 8'h11, 8'h00);
    push_exp(1, 1'b0, 8'h33, 8'h00, 8'h3C);
    wait_done(4, "t3");
    req = '0;

    // 4: three wait states; latency must grow from 4 to 7 and latched fields must not follow req
    @(negedge pclk);
    wait_states = 3;
    set_req(0, 1'b1, 8'h44, 8'h66);
    push_exp(0, 1'b1, 8'h44, 8'h66, 8'h00);
    @(negedge pclk); #1;
    check("t4_gnt", gnt, 2'b01);
    lat = 0;
    gnt_dropped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk); #1;
      lat++;
      if (lat == 1) begin
        req_addr[7:0]  = 8'hEE;
        req_wdata[7:0] = 8'h00;
      end
      if (done != '0) break;
      if (gnt != 2'b01) gnt_dropped = 1'b1;
    end
    check("t4_latency", lat, 7);
    check("t4_gnt_held", gnt_dropped, 0);
    check("t4_paddr_stable", apb_write_paddr, 8'h44);
    check("t4_pwdata_stable", apb_write_data, 8'h66);
    req = '0;
    wait_states = 0;

    // 5: reset during the access phase abandons the transfer
    @(negedge pclk);
    wait_states = 100;
    set_req(0, 1'b1, 8'h55, 8'h99);
    lat = 0;
    while (m_state != M_ACCESS && lat < 50) begin
      @(negedge pclk);
      lat++;
    end
    check("t5_reached_access", m_state == M_ACCESS, 1);
    @(negedge pclk); #2;
    presetn = 1'b0;
    #1;
    check("t5_gnt", gnt, 0);
    check("t5_done", done, 0);
    check("t5_transfer", transfer, 0);
    check("t5_rdata", rdata, 0);
    check("t5_waddr", apb_write_paddr, 0);
    check("t5_wdata", apb_write_data, 0);
    exp_q.delete();
    last_rd = '0;
    req = '0;
    wait_states = 0;
    prdata = 8'hA7;
    set_req(1, 1'b0, 8'h77, 8'h00);
    push_exp(1, 1'b0, 8'h77, 8'h00, 8'hA7);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk); #1;
    check("t5_gnt_after_reset", gnt, 2'b10);
    wait_done(1, "t5");
    req = '0;

    // 6: requester 0 asks for lock while both request
    @(negedge pclk);
    set_req(0, 1'b1, 8'h60, 8'h0F);
    set_req(1, 1'b1, 8'h61, 8'hF0);
    req_lock = 2'b01;
`ifdef ARB_LOCK_EN
    push_exp(0, 1'b1, 8'h60, 8'h0F, 8'h00);
    push_exp(0, 1'b1, 8'h60, 8'h0F, 8'h00);
    push_exp(0, 1'b1, 8'h60, 8'h0F, 8'h00);
    push_exp(1, 1'b1, 8'h61, 8'hF0, 8'h00);
    @(negedge pclk); #1;
    check("t6_gnt", gnt, 2'b01);
    gnt_zero = 0;
    watch = 1'b1;
    wait_done(2, "t6a");
    req_lock = '0;
    wait_done(1, "t6b");
    watch = 1'b0;
    check("t6_no_gnt_drop", gnt_zero, 0);
    wait_done(1, "t6c");
`else
    push_exp(0, 1'b1, 8'h60, 8'h0F, 8'h00);
    push_exp(1, 1'b1, 8'h61, 8'hF0, 8'h00);
    @(negedge pclk); #1;
    check("t6_gnt", gnt, 2'b01);
    wait_done(2, "t6");
`endif
    req = '0;
    req_lock = '0;
    repeat (3) @(negedge pclk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
